// File: rtl/alu_pkg.sv
// Shared ALU control encodings and FSM state type, also imported by the ALU decoder.
// ALU_SRA_EN enables iterative SRA on code 011; otherwise 011 is reserved (result 0).
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SRA = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_t;

  function automatic logic is_shift_op(input logic [2:0] ctrl);
`ifdef ALU_SRA_EN
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
`else
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
`endif
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: ADD/SUB/XOR/OR/AND plus the reserved code.
// Shift codes pass a through, which is the correct result for a zero shift amount.
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = a;
    case (alu_ctrl)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a + ~b + XLEN'(1);
      ALU_XOR: y = a ^ b;
      ALU_OR:  y = a | b;
      ALU_AND: y = a & b;
`ifndef ALU_SRA_EN
      ALU_SRA: y = '0;
`endif
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU with one-bit-per-cycle shifts and a start/busy/done handshake.
// Define ALU_SRA_EN to add iterative SRA on code 011.
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            neg,
  output logic            busy,
  output logic            done
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_state_t          r_state;
  alu_state_t          w_next_state;
  logic [XLEN-1:0]     r_acc;
  logic [SHAMT_W-1:0]  r_cnt;
  logic                r_left;
  logic                r_fill;
  logic [XLEN-1:0]     r_result;
  logic                r_zero;
  logic                r_neg;
  logic                r_done;

  logic [SHAMT_W-1:0]  w_shamt;
  logic [XLEN-1:0]     w_comb;
  logic                w_accept;
  logic                w_launch;
  logic                w_finish;
  logic                w_left_a;
  logic                w_fill_a;
  logic [XLEN-1:0]     w_a_step;
  logic [XLEN-1:0]     w_acc_step;
  logic [XLEN-1:0]     w_res_d;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .alu_ctrl (alu_ctrl),
    .a        (a),
    .b        (b),
    .y        (w_comb)
  );

  assign w_shamt  = b[SHAMT_W-1:0];
  assign w_left_a = (alu_ctrl == ALU_SLL);
`ifdef ALU_SRA_EN
  assign w_fill_a = (alu_ctrl == ALU_SRA) & a[XLEN-1];
`else
  assign w_fill_a = 1'b0;
`endif

  // The first shift step happens on the start edge, so a shift by n finishes n+1 edges later.
  assign w_a_step   = w_left_a ? {a[XLEN-2:0], 1'b0} : {w_fill_a, a[XLEN-1:1]};
  assign w_acc_step = r_left ? {r_acc[XLEN-2:0], 1'b0} : {r_fill, r_acc[XLEN-1:1]};
  assign w_res_d    = w_finish ? r_acc : w_comb;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_launch     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (is_shift_op(alu_ctrl) && (w_shamt != '0)) begin
            w_launch     = 1'b1;
            w_next_state = SHIFT;
          end else begin
            w_accept = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (r_cnt == '0) begin
          w_finish     = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
      r_fill   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_accept | w_finish;
      if (w_accept | w_finish) begin
        r_result <= w_res_d;
        r_zero   <= (w_res_d == '0);
        r_neg    <= w_res_d[XLEN-1];
      end
      if (w_launch) begin
        r_acc  <= w_a_step;
        r_cnt  <= w_shamt - SHAMT_W'(1);
        r_left <= w_left_a;
        r_fill <= w_fill_a;
      end else if ((r_state == SHIFT) && !w_finish) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt - SHAMT_W'(1);
      end
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
  assign neg    = r_neg;
  assign busy   = (r_state == SHIFT);
  assign done   = r_done;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: expected results queued at start, compared on each done pulse.
// Build with ALU_SRA_EN defined to exercise the SRA variant of code 011.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  alu_ctrl = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        zero, neg, busy, done;

  int checks = 0;
  int errors = 0;
  logic [33:0] sb[$];  // {result, zero, neg}

  alu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl), .a(a), .b(b),
    .result(result), .zero(zero), .neg(neg), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    logic [4:0] sh;
    sh = y[4:0];
    case (c)
      3'b000: return x + y;
      3'b010: return x - y;
      3'b001: return x << sh;
      3'b101: return x >> sh;
      3'b100: return x ^ y;
      3'b110: return x | y;
      3'b111: return x & y;
`ifdef ALU_SRA_EN
      default: return 32'($signed(x) >>> sh);
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] c, input logic [31:0] y);
    logic shift;
`ifdef ALU_SRA_EN
    shift = (c == 3'b001) || (c == 3'b101) || (c == 3'b011);
`else
    shift = (c == 3'b001) || (c == 3'b101);
`endif
    return (shift && (y[4:0] != 5'd0)) ? int'(y[4:0]) + 1 : 1;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result=%h with nothing expected", result);
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        if ({result, zero, neg} !== e) begin
          errors++;
          $display("FAIL sb_result: got res=%h z=%b n=%b, want res=%h z=%b n=%b",
                   result, zero, neg, e[33:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] r);
    sb.push_back({r, (r == 32'h0), r[31]});
  endtask

  // Issue one op; optionally hold a bogus ADD start for 'junk' cycles while busy.
  task automatic do_op(input string name, input logic [2:0] c, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat,
                       input int junk);
    int n;
    int busy_n;
    @(posedge clk);
    #1;
    alu_ctrl = c; a = x; b = y; start = 1'b1;
    push_exp(exp_res);
    @(posedge clk);
    #1;
    if (junk > 0) begin
      alu_ctrl = 3'b000; a = 32'h1234; b = 32'h1; start = 1'b1;
    end else begin
      start = 1'b0;
    end
    n = 0;
    busy_n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) busy_n++;
      if (n >= junk) start = 1'b0;
      if (done === 1'b1) break;
      if (n >= 40) break;
    end
    start = 1'b0;
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want %0d", name, n, exp_lat);
    end
    checks++;
    if (busy_n !== exp_lat - 1) begin
      errors++;
      $display("FAIL %s_busy: busy for %0d cycles, want %0d", name, busy_n, exp_lat - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({result, zero, neg, busy, done} !== 37'h0) begin
      errors++;
      $display("FAIL reset_state: res=%h z=%b n=%b busy=%b done=%b, want all 0",
               result, zero, neg, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_cycle();
    do_op("add", 3'b000, 32'd7, 32'd5, 32'd12, 1, 0);
    do_op("sub_zero", 3'b010, 32'd5, 32'd5, 32'h0, 1, 0);
    do_op("sub_neg", 3'b010, 32'd3, 32'd5, 32'hFFFF_FFFE, 1, 0);
    do_op("or", 3'b110, 32'hA000_0000, 32'h0000_0005, 32'hA000_0005, 1, 0);
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  c;
      logic [31:0] x, y;
      c = (i % 2 == 0) ? 3'b100 : 3'b111;
      x = $urandom;
      y = $urandom;
      do_op("rand_logic", c, x, y, model(c, x, y), 1, 0);
    end
  endtask

  task automatic test_sll();
    do_op("sll4", 3'b001, 32'h1, 32'd4, 32'h10, 5, 0);
    do_op("sll_b24", 3'b001, 32'h1, 32'h24, 32'h10, 5, 0);
    do_op("sll0", 3'b001, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1, 0);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom_range(0, 40);
      do_op("rand_sll", 3'b001, x, y, model(3'b001, x, y), model_lat(3'b001, y), 0);
    end
  endtask

  task automatic test_srl();
    do_op("srl31_ignore", 3'b101, 32'h8000_0000, 32'd31, 32'h1, 32, 3);
    do_op("srl7", 3'b101, 32'hF000_00FF, 32'd7, model(3'b101, 32'hF000_00FF, 32'd7), 8, 0);
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    alu_ctrl = 3'b000; a = 32'd1; b = 32'd1; start = 1'b1;
    push_exp(32'd2);
    @(posedge clk);
    #1;
    alu_ctrl = 3'b100; a = 32'hF0; b = 32'hFF;
    push_exp(32'h0F);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done0: done=%b want 1", done); end
    @(posedge clk);
    #1;
    alu_ctrl = 3'b111; a = 32'hF0; b = 32'h3C;
    push_exp(32'h30);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1: done=%b want 1", done); end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: done=%b want 1", done); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_done3: done=%b want 0", done); end
  endtask

  task automatic test_reset_mid_shift();
    @(posedge clk);
    #1;
    alu_ctrl = 3'b101; a = 32'hFFFF_FFFF; b = 32'd10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_shift_busy: busy=%b want 1", busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({result, zero, neg, busy, done} !== 37'h0) begin
      errors++;
      $display("FAIL rst_mid_shift: res=%h z=%b n=%b busy=%b done=%b, want all 0",
               result, zero, neg, busy, done);
    end
    repeat (15) @(posedge clk);
  endtask

  task automatic test_code011();
`ifdef ALU_SRA_EN
    do_op("sra4", 3'b011, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, 0);
    do_op("sra_pos", 3'b011, 32'h4000_0000, 32'd3, 32'h0800_0000, 4, 0);
`else
    do_op("rsvd011", 3'b011, 32'h8000_0000, 32'd4, 32'h0, 1, 0);
`endif
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_sll();
    test_srl();
    test_back_to_back();
    test_reset_mid_shift();
    test_code011();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results never produced, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
